interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 VEC_NMI, 16'hFFFA, NMI vector low-byte address.
REQ-002 VEC_RES, 16'hFFFC, reset vector low-byte address.
REQ-003 VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address.
REQ-004 phi2  in  1  sole clock; all state updates on falling edge of phi2.
REQ-005 resb  in  1  asynchronous active-low reset.
REQ-006 rst_req  in  1  one-cycle reset-sequence request from reset counter.
REQ-007 nmib  in  1  NMI, active-low, falling-edge sensitive.
REQ-008 irqb  in  1  IRQ, active-low, level sensitive.
REQ-009 rdy  in  1  1 = advance; 0 = hold.
REQ-010 boundary  in  1  one-cycle pulse at instruction boundary (opcode fetch).
REQ-011 brk_op  in  1  BRK decoded; valid only with boundary.
REQ-012 i_flag  in  1  current P.I.
REQ-013 sp_in  in  8  current stack pointer (datapath-owned).
REQ-014 seq_busy  out  1  sequence in progress.
REQ-015 addr_out  out  16  address driven in C2..C6.
REQ-016 addr_pc_sel  out  1  1 in C0/C1: address bus sourced from PC.
REQ-017 push_sel  out  2  00 PCH, 01 PCL, 10 P, 11 none.
REQ-018 rwb  out  1  0 = write cycle.
REQ-019 vpb  out  1  low during vector fetch.
REQ-020 sp_decrement  out  1  pulse per push cycle.
REQ-021 load_pcl, load_pch  out  1 each  capture data bus into PCL/PCH.
REQ-022 set_i, clear_d  out  1 each  flag-update pulses.
REQ-023 b_out  out  1  B bit for pushed P: 1 BRK, 0 hardware source.
REQ-024 nmi_pending  out  1  latched, unserviced NMI edge.

Function
REQ-025 States IDLE, C0..C6; IDLE->C0 on accepted request; Cn->Cn+1 per enabled cycle; C6->IDLE.
REQ-026 rdy=0: state, latched source and all outputs frozen; NMI edge detection keeps running.
REQ-027 Arbitration only in IDLE with boundary=1: rst_req > nmi_pending > (~irqb & ~i_flag) > brk_op; none -> stay IDLE.
REQ-028 rst_req accepted in any state without boundary; next state C0, source RES; in-flight sequence aborted.
REQ-029 NMI edge: nmib_q registered; nmi_pending set when nmib_q=1 & nmib=0; cleared on NMI acceptance or hijack; set wins on coincidence.
REQ-030 Hijack: source IRQ/BRK and nmi_pending=1 on entry to C5 -> vector VEC_NMI, nmi_pending cleared, b_out unchanged.
REQ-031 C0, C1: addr_pc_sel=1, rwb=1, push_sel=11, no pulses.
REQ-032 C2/C3/C4: addr_out={8'h01, sp_in}, push_sel 00/01/10, sp_decrement=1; rwb=0 for IRQ/NMI/BRK, rwb=1 for RES (writes suppressed, SP still decremented).
REQ-033 C5: addr_out=vector, vpb=0, rwb=1, load_pcl=1.
REQ-034 C6: addr_out=vector+1 (16-bit wrap), vpb=0, rwb=1, load_pch=1, set_i=1, clear_d=1.
REQ-035 IDLE: addr_out=16'h0000, push_sel=11, rwb=1, vpb=1, all pulses 0, seq_busy=0; seq_busy=1 in C0..C6.
REQ-036 irqb negation or i_flag change after acceptance does not abort.
REQ-037 boundary during C0..C6 ignored; sequence latency fixed at 7 enabled cycles.

Reset
REQ-038 resb=0 immediately forces IDLE, source cleared, nmi_pending=0, nmib_q=1, outputs per REQ-035; release takes effect at next falling phi2.

Verification
REQ-039 rst_req, sp_in FD/FC/FB -> C2..C4 rwb=1, addr 01FD/01FC/01FB, 3 sp_decrement; C5 FFFC vpb=0; C6 FFFD set_i, clear_d.
REQ-040 irqb=0, i_flag=0, boundary -> rwb=0 in C2..C4, push_sel 00/01/10, b_out=0, vectors FFFE/FFFF.
REQ-041 irqb=0, i_flag=1, boundary -> stays IDLE; add brk_op=1 -> BRK, b_out=1, vector FFFE.
REQ-042 BRK accepted, nmib falls in C3 -> C5 addr FFFA, nmi_pending 1->0, b_out=1.
REQ-043 rdy=0 for 3 cycles in C3 -> outputs held, completes in 10 cycles; nmib fall during stall latched.
REQ-044 resb=0 in C4 -> idle outputs without clock edge; nmi_pending=0; rst_req in C5 -> restart C0 with RES.

Source files
------------

// File: rtl/interrupt_sequencer_if.sv
// Signal bundle between the interrupt sequencer and the CPU core/datapath.
interface interrupt_sequencer_if;
  logic        rst_req;
  logic        nmib;
  logic        irqb;
  logic        rdy;
  logic        boundary;
  logic        brk_op;
  logic        i_flag;
  logic [7:0]  sp_in;
  logic        seq_busy;
  logic [15:0] addr_out;
  logic        addr_pc_sel;
  logic [1:0]  push_sel;
  logic        rwb;
  logic        vpb;
  logic        sp_decrement;
  logic        load_pcl;
  logic        load_pch;
  logic        set_i;
  logic        clear_d;
  logic        b_out;
  logic        nmi_pending;

  // Core/datapath side: drives requests and status, consumes sequencer controls.
  modport master (
    output rst_req, nmib, irqb, rdy, boundary, brk_op, i_flag, sp_in,
    input  seq_busy, addr_out, addr_pc_sel, push_sel, rwb, vpb, sp_decrement,
           load_pcl, load_pch, set_i, clear_d, b_out, nmi_pending
  );

  // Sequencer side.
  modport slave (
    input  rst_req, nmib, irqb, rdy, boundary, brk_op, i_flag, sp_in,
    output seq_busy, addr_out, addr_pc_sel, push_sel, rwb, vpb, sp_decrement,
           load_pcl, load_pch, set_i, clear_d, b_out, nmi_pending
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// 7-cycle RES/NMI/IRQ/BRK entry sequencer: two dummy cycles, three stack
// pushes, two vector fetches. All state advances on the falling edge of phi2.
module interrupt_sequencer (
  input logic                  phi2,
  input logic                  resb,
  interrupt_sequencer_if.slave bus
);

  localparam int unsigned ADDR_W = 16;
  localparam logic [ADDR_W-1:0] VEC_NMI = 16'hFFFA;
  localparam logic [ADDR_W-1:0] VEC_RES = 16'hFFFC;
  localparam logic [ADDR_W-1:0] VEC_IRQ = 16'hFFFE;

  typedef enum logic [2:0] {
    S_IDLE, S_C0, S_C1, S_C2, S_C3, S_C4, S_C5, S_C6
  } state_t;

  typedef enum logic [2:0] {
    SRC_NONE, SRC_RES, SRC_NMI, SRC_IRQ, SRC_BRK
  } src_t;

  state_t state_q, state_d;
  src_t   src_q, src_d;
  logic   hijack_q, hijack_d;
  logic   nmib_q;
  logic   nmi_pending_q, nmi_pending_d;
  logic   nmi_take;

  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] vector;
  logic              pc_sel;
  logic [1:0]        push;
  logic              rw;
  logic              vp;
  logic              sp_dec;
  logic              ld_pcl;
  logic              ld_pch;
  logic              seti;
  logic              clrd;
  logic              b_bit;

  // State, latched source and NMI edge detector registers.
  always_ff @(negedge phi2 or negedge resb) begin
    if (!resb) begin
      state_q       <= S_IDLE;
      src_q         <= SRC_NONE;
      hijack_q      <= 1'b0;
      nmib_q        <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      hijack_q      <= hijack_d;
      nmib_q        <= bus.nmib;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  // Next state: reset request overrides everything, arbitration only at an idle boundary.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    hijack_d = hijack_q;
    nmi_take = 1'b0;
    if (bus.rdy) begin
      if (bus.rst_req) begin
        state_d  = S_C0;
        src_d    = SRC_RES;
        hijack_d = 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.boundary) begin
              if (nmi_pending_q) begin
                state_d  = S_C0;
                src_d    = SRC_NMI;
                nmi_take = 1'b1;
              end else if (!bus.irqb && !bus.i_flag) begin
                state_d = S_C0;
                src_d   = SRC_IRQ;
              end else if (bus.brk_op) begin
                state_d = S_C0;
                src_d   = SRC_BRK;
              end
            end
          end
          S_C0: state_d = S_C1;
          S_C1: state_d = S_C2;
          S_C2: state_d = S_C3;
          S_C3: state_d = S_C4;
          S_C4: begin
            state_d = S_C5;
            // A pending NMI steals the vector of an IRQ/BRK that has already pushed.
            if ((src_q == SRC_IRQ || src_q == SRC_BRK) && nmi_pending_q) begin
              hijack_d = 1'b1;
              nmi_take = 1'b1;
            end
          end
          S_C5: state_d = S_C6;
          S_C6: begin
            state_d  = S_IDLE;
            src_d    = SRC_NONE;
            hijack_d = 1'b0;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Edge capture runs regardless of rdy; a new edge beats a same-cycle clear.
  always_comb begin
    nmi_pending_d = (nmib_q & ~bus.nmib) | (nmi_pending_q & ~nmi_take);
  end

  // Vector selection for the current source.
  always_comb begin
    vector = VEC_IRQ;
    if (hijack_q || src_q == SRC_NMI) begin
      vector = VEC_NMI;
    end else if (src_q == SRC_RES) begin
      vector = VEC_RES;
    end
  end

  // Bus and control decode from the current cycle.
  always_comb begin
    busy   = (state_q != S_IDLE);
    addr   = '0;
    pc_sel = 1'b0;
    push   = 2'b11;
    rw     = 1'b1;
    vp     = 1'b1;
    sp_dec = 1'b0;
    ld_pcl = 1'b0;
    ld_pch = 1'b0;
    seti   = 1'b0;
    clrd   = 1'b0;
    b_bit  = busy && (src_q == SRC_BRK);
    case (state_q)
      S_C0, S_C1: pc_sel = 1'b1;
      S_C2, S_C3, S_C4: begin
        addr   = {8'h01, bus.sp_in};
        push   = (state_q == S_C2) ? 2'b00 : (state_q == S_C3) ? 2'b01 : 2'b10;
        rw     = (src_q == SRC_RES);
        sp_dec = 1'b1;
      end
      S_C5: begin
        addr   = vector;
        vp     = 1'b0;
        ld_pcl = 1'b1;
      end
      S_C6: begin
        addr   = vector + 16'd1;
        vp     = 1'b0;
        ld_pch = 1'b1;
        seti   = 1'b1;
        clrd   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.seq_busy     = busy;
  assign bus.addr_out     = addr;
  assign bus.addr_pc_sel  = pc_sel;
  assign bus.push_sel     = push;
  assign bus.rwb          = rw;
  assign bus.vpb          = vp;
  assign bus.sp_decrement = sp_dec;
  assign bus.load_pcl     = ld_pcl;
  assign bus.load_pch     = ld_pch;
  assign bus.set_i        = seti;
  assign bus.clear_d      = clrd;
  assign bus.b_out        = b_bit;
  assign bus.nmi_pending  = nmi_pending_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: each accepted sequence pushes its
// seven expected bus cycles; every enabled busy cycle pops and compares one.
module tb_interrupt_sequencer;

  typedef struct packed {
    logic        chk_addr;
    logic [15:0] addr;
    logic [10:0] ctl;
  } rec_t;

  // ctl = {addr_pc_sel, push_sel, rwb, vpb, sp_decrement, load_pcl, load_pch, set_i, clear_d, b_out}
  localparam logic [10:0] CTL_IDLE = {1'b0, 2'b11, 1'b1, 1'b1, 5'b00000, 1'b0};

  logic       phi2 = 1'b1;
  logic       resb;
  logic [7:0] sp = 8'hFD;
  int         checks = 0;
  int         failures = 0;
  int         busy_cycles = 0;
  int         n;
  rec_t       sb[$];
  rec_t       last;

  interrupt_sequencer_if bus();

  interrupt_sequencer dut (
    .phi2 (phi2),
    .resb (resb),
    .bus  (bus)
  );

  always #5 phi2 = ~phi2;

  // Datapath stack pointer model.
  always @(negedge phi2) begin
    if (bus.rdy && bus.sp_decrement) sp <= sp - 8'd1;
  end
  assign bus.sp_in = sp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ctl_now();
    return {bus.addr_pc_sel, bus.push_sel, bus.rwb, bus.vpb, bus.sp_decrement,
            bus.load_pcl, bus.load_pch, bus.set_i, bus.clear_d, bus.b_out};
  endfunction

  function automatic rec_t mk(input int c, input logic res, input logic brk,
                              input logic [15:0] vec, input logic [7:0] sp0);
    rec_t r;
    r.chk_addr = 1'b1;
    r.addr     = '0;
    r.ctl      = '0;
    case (c)
      0, 1: begin
        r.chk_addr = 1'b0;
        r.ctl = {1'b1, 2'b11, 1'b1, 1'b1, 5'b00000, brk};
      end
      2, 3, 4: begin
        r.addr = {8'h01, 8'(sp0 - 8'(c - 2))};
        r.ctl  = {1'b0, 2'(c - 2), res, 1'b1, 5'b10000, brk};
      end
      5: begin
        r.addr = vec;
        r.ctl  = {1'b0, 2'b11, 1'b1, 1'b0, 5'b01000, brk};
      end
      default: begin
        r.addr = vec + 16'd1;
        r.ctl  = {1'b0, 2'b11, 1'b1, 1'b0, 5'b00111, brk};
      end
    endcase
    return r;
  endfunction

  task automatic push_seq(input logic res, input logic brk, input logic [15:0] vec);
    for (int c = 0; c < 7; c++) sb.push_back(mk(c, res, brk, vec, sp));
  endtask

  // One falling edge, then sample mid-cycle and score the cycle if it advanced.
  task automatic step();
    @(negedge phi2);
    @(posedge phi2);
    if (bus.seq_busy) busy_cycles++;
    if (resb && bus.rdy && bus.seq_busy) begin
      check("sb_avail", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        last = sb.pop_front();
        if (last.chk_addr) check("addr", 32'(bus.addr_out), 32'(last.addr));
        check("ctl", 32'(ctl_now()), 32'(last.ctl));
      end
    end
  endtask

  task automatic run_idle(output int steps);
    steps = 0;
    while (bus.seq_busy && steps < 20) begin
      step();
      steps++;
    end
    check("to_idle", 32'(bus.seq_busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.seq_busy), 32'd0);
    check({tag, "_addr"}, 32'(bus.addr_out), 32'd0);
    check({tag, "_ctl"}, 32'(ctl_now()), 32'(CTL_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    resb         = 1'b0;
    bus.rst_req  = 1'b0;
    bus.nmib     = 1'b1;
    bus.irqb     = 1'b1;
    bus.rdy      = 1'b1;
    bus.boundary = 1'b0;
    bus.brk_op   = 1'b0;
    bus.i_flag   = 1'b1;
    repeat (3) @(posedge phi2);
    check_idle("reset");
    check("reset_nmi", 32'(bus.nmi_pending), 32'd0);
    resb = 1'b1;
    step();
    check_idle("post_reset");

    // Reset sequence: pushes suppressed, SP still walks down.
    bus.rst_req = 1'b1;
    push_seq(1'b1, 1'b0, 16'hFFFC);
    step();
    bus.rst_req = 1'b0;
    run_idle(n);
    check("res_steps", 32'(n), 32'd7);
    check("res_sp", 32'(sp), 32'hFA);

    // IRQ; negating irqb and setting I after acceptance must not abort.
    bus.irqb = 1'b0;
    bus.i_flag = 1'b0;
    bus.boundary = 1'b1;
    push_seq(1'b0, 1'b0, 16'hFFFE);
    step();
    bus.boundary = 1'b0;
    bus.irqb = 1'b1;
    bus.i_flag = 1'b1;
    run_idle(n);

    // Masked IRQ stays idle; BRK at the same boundary is taken.
    bus.irqb = 1'b0;
    bus.boundary = 1'b1;
    step();
    check("masked_irq", 32'(bus.seq_busy), 32'd0);
    bus.brk_op = 1'b1;
    push_seq(1'b0, 1'b1, 16'hFFFE);
    step();
    bus.boundary = 1'b0;
    bus.brk_op = 1'b0;
    bus.irqb = 1'b1;
    run_idle(n);

    // BRK hijacked by an NMI edge arriving in C3.
    bus.boundary = 1'b1;
    bus.brk_op = 1'b1;
    push_seq(1'b0, 1'b1, 16'hFFFA);
    step();
    bus.boundary = 1'b0;
    bus.brk_op = 1'b0;
    repeat (3) step();
    bus.nmib = 1'b0;
    step();
    check("hijack_pend_c4", 32'(bus.nmi_pending), 32'd1);
    step();
    check("hijack_pend_c5", 32'(bus.nmi_pending), 32'd0);
    bus.nmib = 1'b1;
    run_idle(n);

    // Three-cycle stall in C3 with an NMI edge during the stall.
    busy_cycles = 0;
    bus.rst_req = 1'b1;
    push_seq(1'b1, 1'b0, 16'hFFFC);
    step();
    bus.rst_req = 1'b0;
    repeat (3) step();
    bus.rdy = 1'b0;
    bus.nmib = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", 32'(bus.addr_out), 32'(last.addr));
      check("stall_ctl", 32'(ctl_now()), 32'(last.ctl));
    end
    check("stall_nmi", 32'(bus.nmi_pending), 32'd1);
    bus.rdy = 1'b1;
    bus.nmib = 1'b1;
    run_idle(n);
    check("stall_len", 32'(busy_cycles), 32'd10);

    // The NMI left pending by the reset sequence is now taken.
    bus.boundary = 1'b1;
    push_seq(1'b0, 1'b0, 16'hFFFA);
    step();
    bus.boundary = 1'b0;
    check("nmi_taken", 32'(bus.nmi_pending), 32'd0);
    run_idle(n);

    // Asynchronous reset in C4 with an NMI pending.
    bus.irqb = 1'b0;
    bus.i_flag = 1'b0;
    bus.boundary = 1'b1;
    push_seq(1'b0, 1'b0, 16'hFFFE);
    step();
    bus.boundary = 1'b0;
    bus.irqb = 1'b1;
    step();
    bus.nmib = 1'b0;
    step();
    step();
    check("abort_pend", 32'(bus.nmi_pending), 32'd1);
    bus.nmib = 1'b1;
    step();
    #1;
    resb = 1'b0;
    #1;
    check_idle("abort");
    check("abort_nmi", 32'(bus.nmi_pending), 32'd0);
    sb.delete();
    #1;
    resb = 1'b1;
    step();
    check("abort_release", 32'(bus.seq_busy), 32'd0);

    // Reset request in C5 restarts the sequence as RES.
    bus.boundary = 1'b1;
    bus.brk_op = 1'b1;
    push_seq(1'b0, 1'b1, 16'hFFFE);
    step();
    bus.boundary = 1'b0;
    bus.brk_op = 1'b0;
    repeat (5) step();
    bus.rst_req = 1'b1;
    sb.delete();
    push_seq(1'b1, 1'b0, 16'hFFFC);
    step();
    bus.rst_req = 1'b0;
    run_idle(n);
    check("restart_steps", 32'(n), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
